// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one parallel payload per frame as
// start bit, DATA_WIDTH payload bits (LSB first), optional parity bit and
// STOP_BITS stop bits. Each frame bit lasts one baud_en interval.
//
// Handshake: while busy=0, a data_valid=1 seen at a rising edge is accepted.
// The payload and the parity controls are latched at that edge. data_ack
// pulses for exactly the following cycle and busy rises in that same cycle.
// Requests made while busy=1 are ignored. There is no back-pressure on the
// serial side.
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_en,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  data_ack,
    output logic [2:0]            fsm_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    stop_cnt;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_bit_q;

    // Debug view of the FSM for observation by checkers.
    assign fsm_state = state;

    // Frame sequencer: acceptance in IDLE, otherwise advance only on baud_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            data_ack  <= 1'b0;
        end else begin
            data_ack <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (data_valid) begin
                        data_q    <= p_data;
                        par_en_q  <= par_en;
                        par_bit_q <= (^p_data) ^ par_typ;
                        data_ack  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_en) begin
                        tx_out  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_en) begin
                        tx_out <= data_q[bit_cnt];
                        if (bit_cnt == LAST_BIT) begin
                            // Clear instead of incrementing so the counter never wraps.
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_en) begin
                        tx_out <= par_bit_q;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (baud_en) begin
                        tx_out <= 1'b1;
                        if (stop_cnt == LAST_STOP) begin
                            // Line stays at 1 in IDLE, so the last stop bit is never cut short.
                            stop_cnt <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer. Four builds share the stimulus:
// 8 data bits with 1 stop bit, 8 with 2 stop bits, 5 with 1, and 9 with 1.
// "sel" chooses which build receives data_valid and is observed.
// Expected frames are packed so that bit i holds the line value after the i-th baud strobe.
module tb_uart_tx_framer;

    logic       clk;
    logic       rst;
    logic       baud_en;
    logic [8:0] p_data;
    logic       dv;
    logic       par_en;
    logic       par_typ;
    int         sel;

    logic       dv0, dv1, dv2, dv3;
    logic       tx0, tx1, tx2, tx3;
    logic       busy0, busy1, busy2, busy3;
    logic       ackw0, ackw1, ackw2, ackw3;
    logic [2:0] st0, st1, st2, st3;

    logic       obs_tx, obs_busy, obs_ack;

    int n_cmp;
    int n_fail;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dv0 = dv && (sel == 0);
    assign dv1 = dv && (sel == 1);
    assign dv2 = dv && (sel == 2);
    assign dv3 = dv && (sel == 3);

    uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_8s1 (
        .clk(clk), .rst(rst), .baud_en(baud_en), .p_data(p_data[7:0]),
        .data_valid(dv0), .par_en(par_en), .par_typ(par_typ),
        .tx_out(tx0), .busy(busy0), .data_ack(ackw0), .fsm_state(st0));

    uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_8s2 (
        .clk(clk), .rst(rst), .baud_en(baud_en), .p_data(p_data[7:0]),
        .data_valid(dv1), .par_en(par_en), .par_typ(par_typ),
        .tx_out(tx1), .busy(busy1), .data_ack(ackw1), .fsm_state(st1));

    uart_tx_framer #(.DATA_WIDTH(5), .STOP_BITS(1)) dut_5s1 (
        .clk(clk), .rst(rst), .baud_en(baud_en), .p_data(p_data[4:0]),
        .data_valid(dv2), .par_en(par_en), .par_typ(par_typ),
        .tx_out(tx2), .busy(busy2), .data_ack(ackw2), .fsm_state(st2));

    uart_tx_framer #(.DATA_WIDTH(9), .STOP_BITS(1)) dut_9s1 (
        .clk(clk), .rst(rst), .baud_en(baud_en), .p_data(p_data),
        .data_valid(dv3), .par_en(par_en), .par_typ(par_typ),
        .tx_out(tx3), .busy(busy3), .data_ack(ackw3), .fsm_state(st3));

    always_comb begin
        obs_tx   = tx0;
        obs_busy = busy0;
        obs_ack  = ackw0;
        case (sel)
            1: begin obs_tx = tx1; obs_busy = busy1; obs_ack = ackw1; end
            2: begin obs_tx = tx2; obs_busy = busy2; obs_ack = ackw2; end
            3: begin obs_tx = tx3; obs_busy = busy3; obs_ack = ackw3; end
            default: ;
        endcase
    end

    // driver: idle cycles with no request
    task automatic idle_cycles(input int n);
        dv = 1'b0;
        baud_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Driver: requests one frame on the selected build and records the line.
    // Called #1 after a rising edge with the build idle. After acceptance the
    // inputs are inverted to show the latched copy is what gets sent.
    task automatic send_frame(input logic [8:0] d, input logic pe, input logic pt,
                              input int period, input bit dv_mid,
                              output logic [15:0] bits, output int nbits,
                              output int busy_cyc, output int ack_first,
                              output int acks_later, output int bad_hold,
                              output bit timeout);
        logic last_tx;
        bit   strobe;
        bits = '0;
        nbits = 0;
        busy_cyc = 0;
        acks_later = 0;
        bad_hold = 0;
        p_data = d;
        par_en = pe;
        par_typ = pt;
        baud_en = (period == 1);
        dv = 1'b1;
        @(posedge clk);
        #1;
        dv = 1'b0;
        p_data = ~d;
        par_en = ~pe;
        par_typ = ~pt;
        ack_first = int'(obs_ack);
        last_tx = obs_tx;
        for (int c = 0; c < 400 && obs_busy; c++) begin
            busy_cyc++;
            if (dv_mid && c == 3) dv = 1'b1;
            if (dv_mid && c == 6) dv = 1'b0;
            strobe = ((c + 1) % period == 0);
            baud_en = strobe;
            @(posedge clk);
            #1;
            acks_later += int'(obs_ack);
            if (strobe) begin
                if (nbits < 16) bits[nbits] = obs_tx;
                nbits++;
            end else if (obs_tx !== last_tx) begin
                bad_hold++;
            end
            last_tx = obs_tx;
        end
        timeout = obs_busy;
        dv = 1'b0;
        baud_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv = 1'b0;
        baud_en = 1'b0;
        p_data = '0;
        par_en = 1'b0;
        par_typ = 1'b0;
        sel = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (tx0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx0); end
        n_cmp++;
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_cmp++;
        if (ackw0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ackw0); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({tx1, tx2, tx3, busy1, busy2, busy3} !== 6'b111000) begin
            n_fail++;
            $display("FAIL reset_other_builds: got %b expected 111000", {tx1, tx2, tx3, busy1, busy2, busy3});
        end
    endtask

    // 0xA5, even parity, strobe every cycle: 0,1,0,1,0,0,1,0,1,0,1
    task automatic test_basic_frame();
        logic [15:0] bits;
        int nb, bc, a0, al, bh;
        bit to;
        sel = 0;
        send_frame(9'h0A5, 1'b1, 1'b0, 1, 1'b0, bits, nb, bc, a0, al, bh, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL basic_timeout: busy never fell"); end
        n_cmp++;
        if (bits !== 16'h054A) begin n_fail++; $display("FAIL basic_bits: got %h expected 054a", bits); end
        n_cmp++;
        if (nb != 11) begin n_fail++; $display("FAIL basic_nbits: got %0d expected 11", nb); end
        n_cmp++;
        if (bc != 11) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 11", bc); end
        n_cmp++;
        if (a0 != 1 || al != 0) begin n_fail++; $display("FAIL basic_ack: got first=%0d later=%0d expected 1/0", a0, al); end
        idle_cycles(2);
    endtask

    // 0x07 with odd parity, even parity, and no parity
    task automatic test_parity();
        logic [15:0] exp_bits [3] = '{16'h040E, 16'h060E, 16'h020E};
        int          exp_n    [3] = '{11, 11, 10};
        logic        pe_v     [3] = '{1'b1, 1'b1, 1'b0};
        logic        pt_v     [3] = '{1'b1, 1'b0, 1'b0};
        logic [15:0] bits;
        int nb, bc, a0, al, bh;
        bit to;
        sel = 0;
        for (int k = 0; k < 3; k++) begin
            send_frame(9'h007, pe_v[k], pt_v[k], 1, 1'b0, bits, nb, bc, a0, al, bh, to);
            n_cmp++;
            if (bits !== exp_bits[k] || nb != exp_n[k] || bc != exp_n[k] || to) begin
                n_fail++;
                $display("FAIL parity_case%0d: got bits=%h n=%0d busy=%0d expected bits=%h n=%0d busy=%0d",
                         k, bits, nb, bc, exp_bits[k], exp_n[k], exp_n[k]);
            end
            idle_cycles(1);
        end
    endtask

    // 2 stop bits, strobe every 4th cycle, no parity, 0x3C
    task automatic test_baud_divided();
        logic [15:0] bits;
        int nb, bc, a0, al, bh;
        bit to;
        sel = 1;
        send_frame(9'h03C, 1'b0, 1'b0, 4, 1'b0, bits, nb, bc, a0, al, bh, to);
        n_cmp++;
        if (bits !== 16'h0678 || nb != 11) begin
            n_fail++; $display("FAIL div4_bits: got %h n=%0d expected 0678 n=11", bits, nb);
        end
        n_cmp++;
        if (bh != 0) begin n_fail++; $display("FAIL div4_hold: got %0d early changes expected 0", bh); end
        n_cmp++;
        if (bc != 44 || to) begin n_fail++; $display("FAIL div4_busy_cycles: got %0d expected 44", bc); end
        n_cmp++;
        if (a0 != 1 || al != 0) begin n_fail++; $display("FAIL div4_ack: got first=%0d later=%0d expected 1/0", a0, al); end
        // same build at full rate with parity shows both stop bits
        send_frame(9'h007, 1'b1, 1'b1, 1, 1'b0, bits, nb, bc, a0, al, bh, to);
        n_cmp++;
        if (bits !== 16'h0C0E || nb != 12 || bc != 12) begin
            n_fail++; $display("FAIL two_stop_bits: got %h n=%0d busy=%0d expected 0c0e n=12 busy=12", bits, nb, bc);
        end
        sel = 0;
        idle_cycles(2);
    endtask

    // request raised mid-frame is ignored; 0x5A odd parity
    task automatic test_ignore_busy();
        logic [15:0] bits;
        int nb, bc, a0, al, bh;
        bit to;
        sel = 0;
        send_frame(9'h05A, 1'b1, 1'b1, 1, 1'b1, bits, nb, bc, a0, al, bh, to);
        n_cmp++;
        if (bits !== 16'h06B4 || nb != 11) begin
            n_fail++; $display("FAIL ignore_bits: got %h n=%0d expected 06b4 n=11", bits, nb);
        end
        n_cmp++;
        if (al != 0 || a0 != 1) begin n_fail++; $display("FAIL ignore_ack: got first=%0d later=%0d expected 1/0", a0, al); end
        idle_cycles(2);
    endtask

    // data_valid held: 0x55 then 0xAA with one IDLE cycle in between
    task automatic test_back_to_back();
        logic [20:0] rec;
        int acks, idle_cnt;
        sel = 0;
        par_en = 1'b0;
        par_typ = 1'b0;
        p_data = 9'h055;
        baud_en = 1'b1;
        dv = 1'b1;
        acks = 0;
        idle_cnt = 0;
        rec = '0;
        @(posedge clk);
        #1;
        p_data = 9'h0AA;
        acks += int'(obs_ack);
        if (!obs_busy) idle_cnt++;
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            rec[i] = obs_tx;
            if (obs_ack) begin
                acks++;
                if (acks == 2) dv = 1'b0;
            end
            if (i < 20 && !obs_busy) idle_cnt++;
        end
        n_cmp++;
        if (rec !== 21'h1AA6AA) begin n_fail++; $display("FAIL b2b_line: got %h expected 1aa6aa", rec); end
        n_cmp++;
        if (acks != 2) begin n_fail++; $display("FAIL b2b_acks: got %0d expected 2", acks); end
        n_cmp++;
        if (idle_cnt != 1) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d expected 1", idle_cnt); end
        n_cmp++;
        if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got %b expected 0", obs_busy); end
        idle_cycles(2);
    endtask

    // reset during payload bit 3, then a clean 0x3C frame
    task automatic test_reset_midframe();
        logic [15:0] bits;
        int nb, bc, a0, al, bh;
        bit to;
        sel = 0;
        p_data = 9'h0A5;
        par_en = 1'b1;
        par_typ = 1'b0;
        baud_en = 1'b1;
        dv = 1'b1;
        @(posedge clk);
        #1;
        dv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_tx !== 1'b0 || obs_busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_bit3: got tx=%b busy=%b expected 0/1", obs_tx, obs_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_ack !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got tx=%b busy=%b ack=%b expected 1/0/0", obs_tx, obs_busy, obs_ack);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs_tx !== 1'b1 || obs_busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got tx=%b busy=%b expected 1/0", obs_tx, obs_busy);
        end
        send_frame(9'h03C, 1'b1, 1'b0, 1, 1'b0, bits, nb, bc, a0, al, bh, to);
        n_cmp++;
        if (bits !== 16'h0478 || nb != 11 || a0 != 1 || to) begin
            n_fail++; $display("FAIL post_reset_frame: got %h n=%0d ack=%0d expected 0478 n=11 ack=1", bits, nb, a0);
        end
        idle_cycles(2);
    endtask

    // 5-bit and 9-bit builds end the payload on bit 4 / bit 8
    task automatic test_widths();
        int          sel_v    [4] = '{2, 2, 3, 3};
        logic [8:0]  d_v      [4] = '{9'h015, 9'h010, 9'h1A5, 9'h100};
        logic        pe_v     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        pt_v     [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] exp_bits [4] = '{16'h00EA, 16'h0060, 16'h0B4A, 16'h0600};
        int          exp_n    [4] = '{8, 7, 12, 11};
        logic [15:0] bits;
        int nb, bc, a0, al, bh;
        bit to;
        for (int k = 0; k < 4; k++) begin
            sel = sel_v[k];
            send_frame(d_v[k], pe_v[k], pt_v[k], 1, 1'b0, bits, nb, bc, a0, al, bh, to);
            n_cmp++;
            if (bits !== exp_bits[k] || nb != exp_n[k] || bc != exp_n[k] || a0 != 1 || to) begin
                n_fail++;
                $display("FAIL width_case%0d: got bits=%h n=%0d busy=%0d expected bits=%h n=%0d busy=%0d",
                         k, bits, nb, bc, exp_bits[k], exp_n[k], exp_n[k]);
            end
            idle_cycles(1);
        end
        sel = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_basic_frame();
        test_parity();
        test_baud_divided();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midframe();
        test_widths();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of payload bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 baud_en  input  1  one-cycle bit-rate strobe; each frame bit lasts from one baud_en cycle to the next.
REQ-006 p_data  input  DATA_WIDTH  parallel payload, sampled on acceptance.
REQ-007 data_valid  input  1  payload request; only meaningful while busy=0.
REQ-008 par_en  input  1  1 = append a parity bit; sampled on acceptance.
REQ-009 par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-010 tx_out  output  1  registered serial line; idle level is 1.
REQ-011 busy  output  1  1 from the cycle after acceptance until the frame completes.
REQ-012 data_ack  output  1  one-cycle pulse in the cycle after a payload is accepted.

Function
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP; busy=1 in every state except IDLE.
REQ-014 Acceptance: IDLE and data_valid=1 at a rising edge, regardless of baud_en.
- Latch p_data, par_en, par_typ.
- Compute parity = XOR(p_data) XOR par_typ.
- Go to START; data_ack=1 for exactly the next cycle.
REQ-015 data_valid=1 while busy=1 shall be ignored: no latch, no data_ack, no effect on the frame in flight.
REQ-016 All non-IDLE transitions and all tx_out changes occur only on cycles with baud_en=1; with baud_en=0 state, counters and tx_out hold.
REQ-017 START, baud_en=1: tx_out<=0; bit counter<=0; go to DATA.
REQ-018 DATA, baud_en=1: tx_out<=latched_data[counter], LSB first; counter+1.
- When counter = DATA_WIDTH-1, go to PARITY if latched par_en=1, else to STOP.
REQ-019 PARITY, baud_en=1: tx_out<=latched parity bit; go to STOP.
REQ-020 STOP, baud_en=1: tx_out<=1; stop counter+1.
- Go to IDLE after STOP_BITS strobes.
REQ-021 IDLE: tx_out holds 1.
REQ-022 Frame length is 1+DATA_WIDTH+par_en+STOP_BITS baud_en intervals; the last stop bit lasts until the next frame's START strobe, so it is never shortened.
REQ-023 Back-to-back: a data_valid held at 1 is accepted on the first cycle the FSM is in IDLE.
REQ-024 Bit counter width is $clog2(DATA_WIDTH); the counter does not wrap within a frame.
REQ-025 Changes to p_data, par_en or par_typ after acceptance do not affect the frame in flight.

Reset
REQ-026 While rst=1, asynchronously and regardless of clk:
- FSM=IDLE, counters=0, latched data and parity registers=0.
- tx_out=1, busy=0, data_ack=0.
REQ-027 Reset mid-frame aborts the frame immediately with no residual bits; after rst deasserts the first acceptance behaves as after power-up.

Verification
REQ-028 DATA_WIDTH=8, STOP_BITS=1, baud_en=1 constantly, p_data=0xA5, par_en=1, par_typ=0 -> data_ack pulses once; tx_out over 11 strobes = 0,1,0,1,0,0,1,0,1,0,1; busy=1 for exactly 11 cycles.
REQ-029 p_data=0x07, par_en=1, par_typ=1 -> parity bit 0; repeat with par_typ=0 -> parity bit 1; with par_en=0 -> 10-bit frame, no parity slot.
REQ-030 baud_en pulsed every 4th cycle, STOP_BITS=2, par_en=0 -> every tx_out bit held exactly 4 cycles; 11 bits total; busy falls after the second stop strobe.
REQ-031 data_valid held high with 0x55 then 0xAA -> two consecutive frames with no extra idle interval beyond the last stop bit; data_valid asserted mid-frame -> no data_ack, first frame unchanged.
REQ-032 rst=1 asserted during DATA bit 3 -> tx_out=1, busy=0 with no clock edge; after release, 0x3C is transmitted correctly as a full frame.
REQ-033 DATA_WIDTH=5 and DATA_WIDTH=9 builds -> counter terminates correctly; bit 4 (or bit 8) is the last payload bit driven before parity/stop.
